rx_ack_nak_scheduler: RTL and testbench
=======================================

// Module: rx_ack_nak_scheduler
// PURPOSE
//  Receive-side DLL controller. Classifies each incoming TLP against NEXT_RCV_SEQ as good, duplicate or bad.
//  Drives the increment strobe of the next-receive-sequence counter.
//  Schedules Ack/Nak DLLP requests toward the DLLP TX arbiter, using the ack latency timer and coalescing.
//  Sits between the RX TLP framer/LCRC checker, the NRS counter and the DLLP TX arbiter.
// PARAMETERS
//  ACK_LATENCY   255  cycles an unacked good TLP may wait before an Ack is requested
//  ACK_COALESCE  8    number of unacked good TLPs that forces an immediate Ack request
//  TMR_W         16   width of ack latency timer (must hold ACK_LATENCY)
// PORTS
//  clk            in   1   clock
//  rst            in   1   asynchronous, active-low reset
//  dl_down        in   1   DL not active; synchronous clear of all state
//  tlp_valid      in   1   1-cycle strobe: TLP end, seq/lcrc fields valid
//  tlp_seq        in   12  sequence number carried by the TLP
//  tlp_lcrc_ok    in   1   LCRC good and TLP not nullified
//  next_rcv_seq   in   12  current NEXT_RCV_SEQ from counter
//  nrs_inc        out  1   increment NEXT_RCV_SEQ (combinational)
//  tlp_accept     out  1   forward TLP to TL (combinational, == nrs_inc)
//  dllp_req       out  1   Ack/Nak DLLP request, held until grant
//  dllp_is_nak    out  1   1 = Nak, 0 = Ack; stable while dllp_req
//  dllp_seq       out  12  AckNak_Seq_Num; stable while dllp_req
//  dllp_gnt       in   1   arbiter took the DLLP this cycle
//  nak_scheduled  out  1   NAK_SCHEDULED flag
// BEHAVIOUR
//  Reset / dl_down: all outputs 0; state IDLE; timer=0; unacked=0; nak_scheduled=0. dl_down wins over all events.
//  Classification (only when tlp_valid && !dl_down), with d = (next_rcv_seq - tlp_seq) mod 4096:
//   - !tlp_lcrc_ok: discard; set nak_pend if !nak_scheduled.
//   - ok && tlp_seq == next_rcv_seq: GOOD -> nrs_inc=tlp_accept=1 same cycle; nak_scheduled<=0; unacked<=unacked+1.
//   - ok && 1 <= d <= 2048: DUPLICATE -> discard; set ack_now.
//   - otherwise: BAD SEQ -> discard; set nak_pend if !nak_scheduled.
//  Counter timing: counter updates at the same edge, so back-to-back tlp_valid every cycle is legal.
//  Latency timer:
//   - Counts +1 per cycle while unacked != 0 and no request is outstanding; saturates.
//   - Cleared when unacked returns to 0.
//  Ack trigger: timer >= ACK_LATENCY, or unacked >= ACK_COALESCE, or ack_now.
//  FSM:
//   - IDLE: if nak_pend -> REQ (is_nak=1, nak_scheduled<=1, nak_pend<=0). Otherwise, on Ack trigger -> REQ (is_nak=0, ack_now<=0).
//     Nak has priority over Ack.
//   - Entering REQ:
//     - dllp_seq latched = next_rcv_seq - 1, using the post-increment value. If GOOD and trigger coincide, latch tlp_seq.
//     - snap latched = unacked.
//     - dllp_req=1 from the next cycle.
//   - REQ: hold req/is_nak/seq until dllp_gnt.
//     - On gnt: -> IDLE; unacked <= unacked - snap (+1 if GOOD same cycle); timer<=0.
//   - New GOOD TLPs during REQ count in unacked and are covered by a later Ack.
//   - A Nak event during REQ(Ack) sets nak_pend, which is served after the grant.
//  nak_scheduled stays 1 until a GOOD TLP arrives. Further bad TLPs schedule no extra Nak.
//  Wrap: all seq arithmetic is mod 4096. next_rcv_seq=0 -> Ack seq 12'hFFF.
//  unacked saturates at its max and never wraps.
// TESTING
//  1 NRS=5, tlp_valid seq=5 ok -> nrs_inc=1 that cycle; no dllp_req until ACK_LATENCY cycles, then Ack seq=5.
//  2 Eight back-to-back good TLPs seq 0..7 -> Ack req seq=7 on the cycle after the 8th; gnt -> unacked=0.
//  3 NRS=10, seq=10 with lcrc_ok=0 -> Nak seq=9, nak_scheduled=1.
//    A second bad TLP makes no new req; seq=10 good clears nak_scheduled.
//  4 NRS=10, seq=7 ok (duplicate) -> no nrs_inc; immediate Ack seq=9.
//    seq=12 ok (bad seq) -> Nak seq=9.
//  5 NRS=12'hFFF, good seq=FFF -> NRS wraps to 0; Ack seq=12'hFFF. seq=12'h800 at NRS=0 -> duplicate.
//  6 Ack req held, gnt low 20 cycles with good TLPs arriving -> req/seq stable.
//    Assert dl_down mid-REQ -> req=0 next cycle, all flags 0; rst low mid-op -> same immediately.

Source files
------------

// File: rtl/rx_ack_nak_scheduler.sv
// rx_ack_nak_scheduler
//   Receive-side data link layer controller. Each incoming TLP is classified
//   as good, duplicate or bad against NEXT_RCV_SEQ. The block drives the
//   counter's increment strobe and schedules Ack/Nak DLLP requests toward the
//   DLLP TX arbiter. Ack requests are triggered by the ack latency timer, by
//   coalescing of unacked good TLPs, or immediately after a duplicate.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   dl_down           DL not active, synchronous clear of all state
//   tlp_valid         1-cycle strobe at TLP end (tlp_seq / tlp_lcrc_ok valid)
//   tlp_seq           sequence number carried by the TLP
//   tlp_lcrc_ok       LCRC good and TLP not nullified
//   next_rcv_seq      current NEXT_RCV_SEQ from the counter
//   nrs_inc           increment NEXT_RCV_SEQ (combinational)
//   tlp_accept        forward TLP to the transaction layer (== nrs_inc)
//   dllp_req          Ack/Nak request, held until dllp_gnt
//   dllp_is_nak       1 = Nak, 0 = Ack; stable while dllp_req
//   dllp_seq          AckNak_Seq_Num; stable while dllp_req
//   dllp_gnt          arbiter took the DLLP this cycle
//   nak_scheduled     NAK_SCHEDULED flag
module rx_ack_nak_scheduler #(
  parameter int unsigned ACK_LATENCY  = 255,
  parameter int unsigned ACK_COALESCE = 8,
  parameter int unsigned TMR_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dl_down,
  input  logic        tlp_valid,
  input  logic [11:0] tlp_seq,
  input  logic        tlp_lcrc_ok,
  input  logic [11:0] next_rcv_seq,
  output logic        nrs_inc,
  output logic        tlp_accept,
  output logic        dllp_req,
  output logic        dllp_is_nak,
  output logic [11:0] dllp_seq,
  input  logic        dllp_gnt,
  output logic        nak_scheduled
);

  localparam int unsigned UNACK_W = 12;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_t;

  state_t              state_q, state_d;
  logic                dllp_req_q, dllp_req_d;
  logic                dllp_is_nak_q, dllp_is_nak_d;
  logic [11:0]         dllp_seq_q, dllp_seq_d;
  logic                nak_scheduled_q, nak_scheduled_d;
  logic                nak_pend_q, nak_pend_d;
  logic                ack_now_q, ack_now_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [UNACK_W-1:0]  unacked_q, unacked_d;
  logic [UNACK_W-1:0]  snap_q, snap_d;

  logic [11:0]         seq_dist;
  logic                ev_valid;
  logic                seq_match;
  logic                is_good;
  logic                is_dup;
  logic                is_bad;
  logic                nak_event;
  logic [UNACK_W-1:0]  unacked_inc;
  logic                ack_trig;
  logic [11:0]         req_seq;

  // Classification and trigger terms
  always_comb begin
    seq_dist  = next_rcv_seq - tlp_seq;
    ev_valid  = tlp_valid && rst && !dl_down;
    seq_match = (tlp_seq == next_rcv_seq);
    is_good   = ev_valid && tlp_lcrc_ok && seq_match;
    // seq_dist is nonzero here because seq_match is false
    is_dup    = ev_valid && tlp_lcrc_ok && !seq_match && (seq_dist <= 12'd2048);
    is_bad    = ev_valid && !is_good && !is_dup;
    nak_event = is_bad && !nak_scheduled_q;

    unacked_inc = (is_good && (unacked_q != '1)) ? unacked_q + 1'b1 : unacked_q;

    // Coalescing looks at the post-increment count so the Ack covering the
    // triggering TLP is requested at the same edge that counts it.
    ack_trig = (timer_q >= TMR_W'(ACK_LATENCY)) ||
               (unacked_inc >= UNACK_W'(ACK_COALESCE)) ||
               ack_now_q || is_dup;

    // Post-increment NEXT_RCV_SEQ - 1 equals tlp_seq when the TLP is good
    req_seq = is_good ? tlp_seq : next_rcv_seq - 12'd1;
  end

  assign nrs_inc       = is_good;
  assign tlp_accept    = is_good;
  assign dllp_req      = dllp_req_q;
  assign dllp_is_nak   = dllp_is_nak_q;
  assign dllp_seq      = dllp_seq_q;
  assign nak_scheduled = nak_scheduled_q;

  // Next-state logic
  always_comb begin
    state_d         = state_q;
    dllp_req_d      = dllp_req_q;
    dllp_is_nak_d   = dllp_is_nak_q;
    dllp_seq_d      = dllp_seq_q;
    nak_scheduled_d = nak_scheduled_q;
    nak_pend_d      = nak_pend_q | nak_event;
    ack_now_d       = ack_now_q | is_dup;
    timer_d         = timer_q;
    unacked_d       = unacked_inc;
    snap_d          = snap_q;

    if (is_good) begin
      nak_scheduled_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (unacked_q == '0) begin
          timer_d = '0;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end

        if (nak_pend_q || nak_event) begin
          state_d         = ST_REQ;
          dllp_req_d      = 1'b1;
          dllp_is_nak_d   = 1'b1;
          dllp_seq_d      = req_seq;
          snap_d          = unacked_inc;
          nak_scheduled_d = 1'b1;
          nak_pend_d      = 1'b0;
        end else if (ack_trig) begin
          state_d       = ST_REQ;
          dllp_req_d    = 1'b1;
          dllp_is_nak_d = 1'b0;
          dllp_seq_d    = req_seq;
          snap_d        = unacked_inc;
          ack_now_d     = 1'b0;
        end
      end

      ST_REQ: begin
        if (dllp_gnt) begin
          state_d       = ST_IDLE;
          dllp_req_d    = 1'b0;
          dllp_is_nak_d = 1'b0;
          // Good TLPs that arrived during REQ remain unacked
          unacked_d     = unacked_inc - snap_q;
          timer_d       = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (dl_down) begin
      state_d         = ST_IDLE;
      dllp_req_d      = 1'b0;
      dllp_is_nak_d   = 1'b0;
      dllp_seq_d      = '0;
      nak_scheduled_d = 1'b0;
      nak_pend_d      = 1'b0;
      ack_now_d       = 1'b0;
      timer_d         = '0;
      unacked_d       = '0;
      snap_d          = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      dllp_req_q      <= 1'b0;
      dllp_is_nak_q   <= 1'b0;
      dllp_seq_q      <= '0;
      nak_scheduled_q <= 1'b0;
      nak_pend_q      <= 1'b0;
      ack_now_q       <= 1'b0;
      timer_q         <= '0;
      unacked_q       <= '0;
      snap_q          <= '0;
    end else begin
      state_q         <= state_d;
      dllp_req_q      <= dllp_req_d;
      dllp_is_nak_q   <= dllp_is_nak_d;
      dllp_seq_q      <= dllp_seq_d;
      nak_scheduled_q <= nak_scheduled_d;
      nak_pend_q      <= nak_pend_d;
      ack_now_q       <= ack_now_d;
      timer_q         <= timer_d;
      unacked_q       <= unacked_d;
      snap_q          <= snap_d;
    end
  end

endmodule

// File: tb/tb_rx_ack_nak_scheduler.sv
// tb_rx_ack_nak_scheduler
//   Directed-vector bench for rx_ack_nak_scheduler. The bench plays the NRS
//   counter (next_rcv_seq advances one step after every accepted TLP) and
//   the DLLP arbiter (dllp_gnt pulses). Inputs change 1 ns after the rising
//   edge; outputs are sampled there as well.
module tb_rx_ack_nak_scheduler;

  localparam int unsigned ACK_LATENCY = 255;

  logic        clk;
  logic        rst;
  logic        dl_down;
  logic        tlp_valid;
  logic [11:0] tlp_seq;
  logic        tlp_lcrc_ok;
  logic [11:0] next_rcv_seq;
  logic        nrs_inc;
  logic        tlp_accept;
  logic        dllp_req;
  logic        dllp_is_nak;
  logic [11:0] dllp_seq;
  logic        dllp_gnt;
  logic        nak_scheduled;

  int vectors;
  int miscompares;

  rx_ack_nak_scheduler #(
    .ACK_LATENCY  (ACK_LATENCY),
    .ACK_COALESCE (8),
    .TMR_W        (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dl_down       (dl_down),
    .tlp_valid     (tlp_valid),
    .tlp_seq       (tlp_seq),
    .tlp_lcrc_ok   (tlp_lcrc_ok),
    .next_rcv_seq  (next_rcv_seq),
    .nrs_inc       (nrs_inc),
    .tlp_accept    (tlp_accept),
    .dllp_req      (dllp_req),
    .dllp_is_nak   (dllp_is_nak),
    .dllp_seq      (dllp_seq),
    .dllp_gnt      (dllp_gnt),
    .nak_scheduled (nak_scheduled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one TLP for a cycle; acc is the expected accept decision
  task automatic tlp(input logic [11:0] seq, input logic ok, input logic acc);
    tlp_valid   = 1'b1;
    tlp_seq     = seq;
    tlp_lcrc_ok = ok;
    #1;
    chk("nrs_inc", {11'd0, nrs_inc}, {11'd0, acc});
    chk("tlp_accept", {11'd0, tlp_accept}, {11'd0, acc});
    @(posedge clk);
    #1;
    tlp_valid = 1'b0;
    if (acc) next_rcv_seq = next_rcv_seq + 12'd1;
  endtask

  task automatic grant();
    dllp_gnt = 1'b1;
    cyc();
    dllp_gnt = 1'b0;
    chk("req_after_gnt", {11'd0, dllp_req}, 12'd0);
  endtask

  task automatic expect_req(input string tag, input logic nak, input logic [11:0] seq);
    chk({tag, "_req"}, {11'd0, dllp_req}, 12'd1);
    chk({tag, "_is_nak"}, {11'd0, dllp_is_nak}, {11'd0, nak});
    chk({tag, "_seq"}, dllp_seq, seq);
  endtask

  task automatic wait_req(input int max_cycles);
    int n;
    n = 0;
    while (!dllp_req && n < max_cycles) begin
      cyc();
      n++;
    end
    chk("req_timeout", {11'd0, dllp_req}, 12'd1);
  endtask

  task automatic clear_dl();
    dl_down = 1'b1;
    cyc();
    dl_down = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b0;
    dl_down      = 1'b0;
    tlp_valid    = 1'b0;
    tlp_seq      = '0;
    tlp_lcrc_ok  = 1'b0;
    next_rcv_seq = '0;
    dllp_gnt     = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("rst_req", {11'd0, dllp_req}, 12'd0);
    chk("rst_is_nak", {11'd0, dllp_is_nak}, 12'd0);
    chk("rst_seq", dllp_seq, 12'd0);
    chk("rst_nak_sched", {11'd0, nak_scheduled}, 12'd0);
    chk("rst_nrs_inc", {11'd0, nrs_inc}, 12'd0);
    rst = 1'b1;
    cyc();

    // 1: single good TLP, Ack only after latency
    next_rcv_seq = 12'd5;
    tlp(12'd5, 1'b1, 1'b1);
    repeat (ACK_LATENCY - 5) cyc();
    chk("t1_no_early_req", {11'd0, dllp_req}, 12'd0);
    wait_req(20);
    expect_req("t1", 1'b0, 12'd5);
    grant();

    // 2: coalescing, eight back-to-back good TLPs
    next_rcv_seq = 12'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i == 7) chk("t2_req_before_8th", {11'd0, dllp_req}, 12'd0);
      tlp(12'(i), 1'b1, 1'b1);
    end
    expect_req("t2", 1'b0, 12'd7);
    grant();
    repeat (300) cyc();
    chk("t2_unacked_cleared", {11'd0, dllp_req}, 12'd0);

    // 3: LCRC error -> Nak, second error suppressed, good TLP clears flag
    next_rcv_seq = 12'd10;
    tlp(12'd10, 1'b0, 1'b0);
    expect_req("t3_nak", 1'b1, 12'd9);
    chk("t3_nak_sched", {11'd0, nak_scheduled}, 12'd1);
    grant();
    tlp(12'd10, 1'b0, 1'b0);
    repeat (3) cyc();
    chk("t3_no_second_nak", {11'd0, dllp_req}, 12'd0);
    chk("t3_nak_sched_held", {11'd0, nak_scheduled}, 12'd1);
    tlp(12'd10, 1'b1, 1'b1);
    chk("t3_nak_sched_clr", {11'd0, nak_scheduled}, 12'd0);
    clear_dl();

    // 4: duplicate -> immediate Ack; out-of-window seq -> Nak
    next_rcv_seq = 12'd10;
    tlp(12'd7, 1'b1, 1'b0);
    expect_req("t4_dup", 1'b0, 12'd9);
    grant();
    tlp(12'd12, 1'b1, 1'b0);
    expect_req("t4_bad", 1'b1, 12'd9);
    grant();
    clear_dl();

    // 5: sequence wrap and duplicate window edge
    next_rcv_seq = 12'hFFF;
    tlp(12'hFFF, 1'b1, 1'b1);
    chk("t5_nrs_wrap", next_rcv_seq, 12'h000);
    wait_req(300);
    expect_req("t5_wrap", 1'b0, 12'hFFF);
    grant();
    tlp(12'h800, 1'b1, 1'b0);
    expect_req("t5_dup2048", 1'b0, 12'hFFF);
    grant();
    tlp(12'h7FF, 1'b1, 1'b0);
    expect_req("t5_bad2049", 1'b1, 12'hFFF);
    grant();
    clear_dl();

    // 6: request held stable while grant stays low and good TLPs arrive
    next_rcv_seq = 12'd20;
    tlp(12'd15, 1'b1, 1'b0);
    expect_req("t6_start", 1'b0, 12'd19);
    for (int unsigned i = 0; i < 20; i++) begin
      tlp(12'd20 + 12'(i), 1'b1, 1'b1);
      if (i % 5 == 4) expect_req("t6_hold", 1'b0, 12'd19);
    end
    // dl_down mid-REQ, with a good TLP that must not be accepted
    dl_down     = 1'b1;
    tlp_valid   = 1'b1;
    tlp_seq     = next_rcv_seq;
    tlp_lcrc_ok = 1'b1;
    #1;
    chk("t6_dl_down_no_inc", {11'd0, nrs_inc}, 12'd0);
    cyc();
    tlp_valid = 1'b0;
    dl_down   = 1'b0;
    chk("t6_dl_req", {11'd0, dllp_req}, 12'd0);
    chk("t6_dl_is_nak", {11'd0, dllp_is_nak}, 12'd0);
    chk("t6_dl_seq", dllp_seq, 12'd0);
    chk("t6_dl_nak_sched", {11'd0, nak_scheduled}, 12'd0);
    // async reset mid-Nak request
    tlp(12'd50, 1'b1, 1'b0);
    expect_req("t6_nak", 1'b1, 12'd39);
    chk("t6_nak_sched", {11'd0, nak_scheduled}, 12'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_req", {11'd0, dllp_req}, 12'd0);
    chk("t6_rst_is_nak", {11'd0, dllp_is_nak}, 12'd0);
    chk("t6_rst_seq", dllp_seq, 12'd0);
    chk("t6_rst_nak_sched", {11'd0, nak_scheduled}, 12'd0);
    cyc();
    rst = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
